// File: rtl/gate_test_sequencer.sv
// gate_test_sequencer
//   Self-checking stimulus sequencer for a single combinational gate cell.
//   After an accepted start it sweeps o_stim through every input combination
//   0 .. 2**N_IN-1. Each vector is held for SETTLE cycles before the gate
//   output i_dut_y is compared with the expected reduction function. The
//   sweep reports a one-cycle o_done pulse, a held o_pass flag and a
//   saturating mismatch count.
//
// Parameters
//   N_IN    gate input count (1..8)
//   SETTLE  cycles each vector settles before it is checked (>=1)
//   GATE    expected function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR
//   CNT_W   width of the mismatch counter
//
// Ports
//   i_clk         rising-edge clock
//   i_rst         synchronous active-high reset
//   i_start       begin a sweep (honoured only when idle)
//   i_abort       stop the sweep and return to idle
//   i_dut_y       output of the gate under test
//   o_stim        vector driven onto the gate inputs (bit i -> input i)
//   o_stim_valid  o_stim is driven and stable
//   o_busy        sweep in progress
//   o_done        one-cycle pulse when a sweep completes
//   o_pass        last sweep completed with no mismatches (held)
//   o_err_cnt     mismatch count, saturating (held)
//   o_fail_valid  a mismatch was captured        (GATE_SEQ_FAIL_CAPTURE_EN)
//   o_fail_vec    first failing stimulus vector   (GATE_SEQ_FAIL_CAPTURE_EN)
//
// Optional build macro
//   GATE_SEQ_FAIL_CAPTURE_EN  adds first-failure capture and its two ports.
module gate_test_sequencer #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 2,
  parameter int GATE   = 0,
  parameter int CNT_W  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_dut_y,
  output logic [N_IN-1:0]  o_stim,
  output logic             o_stim_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [CNT_W-1:0] o_err_cnt
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
  ,
  output logic             o_fail_valid,
  output logic [N_IN-1:0]  o_fail_vec
`endif
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [SW-1:0]    r_settle_cnt;
  logic [N_IN-1:0]  r_stim;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [CNT_W-1:0] r_err_cnt;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
  logic             r_fail_valid;
  logic [N_IN-1:0]  r_fail_vec;
`endif

  logic             w_expected;
  logic             w_mismatch;
  logic [CNT_W-1:0] w_err_next;

  // Golden truth-table value for the vector currently on o_stim. The gate
  // function is a reduction over all stimulus bits, so a fixed-width
  // reduction operator covers every N_IN.
  always_comb begin
    w_expected = 1'b0;
    case (GATE)
      0:       w_expected = &r_stim;
      1:       w_expected = |r_stim;
      2:       w_expected = ^r_stim;
      3:       w_expected = ~&r_stim;
      4:       w_expected = ~|r_stim;
      5:       w_expected = ~^r_stim;
      default: w_expected = &r_stim;
    endcase
  end

  // Mismatch detection and the saturating next value of the error counter.
  // The counter sticks at all-ones rather than wrapping so a badly broken
  // gate can never read back as a small error count.
  always_comb begin
    w_mismatch = (i_dut_y != w_expected);
    w_err_next = r_err_cnt;
    if (w_mismatch && (r_err_cnt != {CNT_W{1'b1}})) begin
      w_err_next = r_err_cnt + CNT_W'(1);
    end
  end

  // Sweep controller. Every output is a register updated alongside the
  // state so the status lines change exactly on state transitions. In CHECK
  // the mismatch is recorded before the abort test, so an abort in that
  // cycle still counts the vector being checked but never advances it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_stim       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_cnt    <= '0;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
      r_fail_valid <= 1'b0;
      r_fail_vec   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            r_state   <= S_DRIVE;
            r_stim    <= '0;
            r_err_cnt <= '0;
            r_pass    <= 1'b0;
            r_busy    <= 1'b1;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
            r_fail_valid <= 1'b0;
            r_fail_vec   <= '0;
`endif
          end
        end
        S_DRIVE: begin
          if (i_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
          end else begin
            r_settle_cnt <= SW'(SETTLE - 1);
            r_state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (i_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
          end else if (r_settle_cnt == '0) begin
            r_state <= S_CHECK;
          end else begin
            r_settle_cnt <= r_settle_cnt - SW'(1);
          end
        end
        S_CHECK: begin
          r_err_cnt <= w_err_next;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
          if (w_mismatch && !r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_fail_vec   <= r_stim;
          end
`endif
          if (i_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
          end else if (&r_stim) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end else begin
            r_stim  <= r_stim + N_IN'(1);
            r_state <= S_DRIVE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_stim       = r_stim;
  assign o_stim_valid = r_busy;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_pass       = r_pass;
  assign o_err_cnt    = r_err_cnt;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
  assign o_fail_valid = r_fail_valid;
  assign o_fail_vec   = r_fail_vec;
`endif

endmodule

// File: tb/tb_gate_test_sequencer.sv
`timescale 1ns/1ps
// Testbench for gate_test_sequencer. Four sequencer instances with
// different parameter sets share start/abort/reset. Each one drives a
// behavioural gate model that can be made stuck or given per-vector output
// flips, and the expected sweep results are derived from the gate's truth
// table and the sweep timing rules.
module tb_gate_test_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic abort;

  int errors = 0;
  int checks = 0;

  // Fault configuration of each gate model
  logic       stuckEn  [4];
  logic       stuckVal [4];
  logic [7:0] flip     [4];

  // Results expected from the most recent sweep, kept for hold checks
  int lastErr  [4];
  bit lastPass [4];

  // Instance A: N_IN=2 SETTLE=2 AND CNT_W=8
  logic [1:0] stimA;
  logic       validA, busyA, doneA, passA, yA;
  logic [7:0] errA;
  // Instance B: N_IN=3 SETTLE=2 XOR CNT_W=8
  logic [2:0] stimB;
  logic       validB, busyB, doneB, passB, yB;
  logic [7:0] errB;
  // Instance C: N_IN=2 SETTLE=2 AND CNT_W=1
  logic [1:0] stimC;
  logic       validC, busyC, doneC, passC, yC;
  logic [0:0] errC;
  // Instance D: N_IN=3 SETTLE=1 NAND CNT_W=8
  logic [2:0] stimD;
  logic       validD, busyD, doneD, passD, yD;
  logic [7:0] errD;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
  logic       failValidA, failValidB, failValidC, failValidD;
  logic [1:0] failVecA, failVecC;
  logic [2:0] failVecB, failVecD;
`endif

  logic [3:0] busyV, validV, doneV, passV;
  logic [9:0] stimAll;
  logic [7:0] errV [4];

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Per-instance parameter lookup used by the reference model
  function automatic int nIn(input int d);
    return (d == 1 || d == 3) ? 3 : 2;
  endfunction
  function automatic int settleOf(input int d);
    return (d == 3) ? 1 : 2;
  endfunction
  function automatic int gateOf(input int d);
    case (d)
      1:       return 2;
      3:       return 3;
      default: return 0;
    endcase
  endfunction
  function automatic int cntWOf(input int d);
    return (d == 2) ? 1 : 8;
  endfunction

  // Truth-table reference written from the gate definitions: count ones
  function automatic logic refGate(input int gate, input int n, input int v);
    int ones;
    ones = 0;
    for (int i = 0; i < n; i++) ones += (v >> i) & 1;
    case (gate)
      0:       return ones == n;
      1:       return ones > 0;
      2:       return (ones % 2) == 1;
      3:       return ones != n;
      4:       return ones == 0;
      default: return (ones % 2) == 0;
    endcase
  endfunction

  // Behavioural gates under test: either stuck, or the correct function
  // with selected vectors inverted
  always_comb begin
    yA = stuckEn[0] ? stuckVal[0] : (refGate(0, 2, int'(stimA)) ^ flip[0][stimA]);
    yB = stuckEn[1] ? stuckVal[1] : (refGate(2, 3, int'(stimB)) ^ flip[1][stimB]);
    yC = stuckEn[2] ? stuckVal[2] : (refGate(0, 2, int'(stimC)) ^ flip[2][stimC]);
    yD = stuckEn[3] ? stuckVal[3] : (refGate(3, 3, int'(stimD)) ^ flip[3][stimD]);
  end

  // Gather instance outputs into vectors for looped checking
  always_comb begin
    busyV   = {busyD, busyC, busyB, busyA};
    validV  = {validD, validC, validB, validA};
    doneV   = {doneD, doneC, doneB, doneA};
    passV   = {passD, passC, passB, passA};
    stimAll = {stimD, stimC, stimB, stimA};
    errV[0] = errA;
    errV[1] = errB;
    errV[2] = {7'b0, errC};
    errV[3] = errD;
  end

  gate_test_sequencer #(.N_IN(2), .SETTLE(2), .GATE(0), .CNT_W(8)) dutA (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_dut_y(yA),
    .o_stim(stimA), .o_stim_valid(validA), .o_busy(busyA), .o_done(doneA),
    .o_pass(passA), .o_err_cnt(errA)
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
    , .o_fail_valid(failValidA), .o_fail_vec(failVecA)
`endif
  );

  gate_test_sequencer #(.N_IN(3), .SETTLE(2), .GATE(2), .CNT_W(8)) dutB (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_dut_y(yB),
    .o_stim(stimB), .o_stim_valid(validB), .o_busy(busyB), .o_done(doneB),
    .o_pass(passB), .o_err_cnt(errB)
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
    , .o_fail_valid(failValidB), .o_fail_vec(failVecB)
`endif
  );

  gate_test_sequencer #(.N_IN(2), .SETTLE(2), .GATE(0), .CNT_W(1)) dutC (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_dut_y(yC),
    .o_stim(stimC), .o_stim_valid(validC), .o_busy(busyC), .o_done(doneC),
    .o_pass(passC), .o_err_cnt(errC)
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
    , .o_fail_valid(failValidC), .o_fail_vec(failVecC)
`endif
  );

  gate_test_sequencer #(.N_IN(3), .SETTLE(1), .GATE(3), .CNT_W(8)) dutD (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_dut_y(yD),
    .o_stim(stimD), .o_stim_valid(validD), .o_busy(busyD), .o_done(doneD),
    .o_pass(passD), .o_err_cnt(errD)
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
    , .o_fail_valid(failValidD), .o_fail_vec(failVecD)
`endif
  );

  // Fault setup: mode 0 correct, 1 stuck-at-1, 2 stuck-at-0, 3 random
  task automatic applyStimulus(input int mode);
    for (int d = 0; d < 4; d++) begin
      stuckEn[d]  = (mode == 1 || mode == 2);
      stuckVal[d] = (mode == 1);
      flip[d]     = 8'h00;
      if (mode == 3) begin
        stuckEn[d]  = ($urandom_range(0, 3) == 0);
        stuckVal[d] = 1'($urandom_range(0, 1));
        flip[d]     = 8'($urandom);
      end
    end
  endtask

  // Expected outcome for instance d: a vector is counted when its check
  // cycle (v*(SETTLE+2)+SETTLE+1 cycles after the start edge) happens
  // before the abort edge
  task automatic computeExp(input int d, input int abortAt, output int err,
                            output int firstFail, output bit anyFail);
    int s, n, cyc;
    logic r, obs;
    s = settleOf(d);
    n = nIn(d);
    err = 0;
    firstFail = 0;
    anyFail = 1'b0;
    for (int v = 0; v < (1 << n); v++) begin
      cyc = v * (s + 2) + s + 1;
      if (abortAt == 0 || cyc <= abortAt - 1) begin
        r   = refGate(gateOf(d), n, v);
        obs = stuckEn[d] ? stuckVal[d] : (r ^ flip[d][v]);
        if (obs != r) begin
          if (err < (1 << cntWOf(d)) - 1) err++;
          if (!anyFail) firstFail = v;
          anyFail = 1'b1;
        end
      end
    end
  endtask

  // One sweep on all instances with optional abort and mid-sweep restart
  task automatic runSweep(input string name, input int abortAt, input int restartAt);
    int total [4];
    int doneAt [4];
    int doneCnt [4];
    int expErrV, firstFail, s0, expDone;
    bit anyFail, expPass;
    logic [1:0] expStim;
    for (int d = 0; d < 4; d++) begin
      total[d]   = (1 << nIn(d)) * (settleOf(d) + 2);
      doneAt[d]  = -1;
      doneCnt[d] = 0;
    end
    s0 = settleOf(0) + 2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        if (doneV[d] === 1'b1) begin
          doneCnt[d]++;
          doneAt[d] = c;
        end
      end
      if (c < total[0] && (abortAt == 0 || c < abortAt)) begin
        expStim = 2'(c / s0);
        checks++;
        if ({busyA, validA, stimA} !== {2'b11, expStim}) begin
          errors++;
          $display("[TB] FAIL %s seqA cycle %0d got busy=%b valid=%b stim=%b exp 1 1 %b",
                   name, c, busyA, validA, stimA, expStim);
        end
      end
      if (abortAt > 0 && c == abortAt) begin
        checks++;
        if (busyV !== 4'b0 || validV !== 4'b0) begin
          errors++;
          $display("[TB] FAIL %s abortIdle got busy=%b valid=%b exp 0000 0000", name, busyV, validV);
        end
      end
      if (abortAt > 0) abort = (c == abortAt - 1);
      if (restartAt > 0) start = (c == restartAt - 1);
    end
    abort = 1'b0;
    start = 1'b0;
    for (int d = 0; d < 4; d++) begin
      computeExp(d, abortAt, expErrV, firstFail, anyFail);
      expPass = (abortAt == 0) && (expErrV == 0);
      expDone = (abortAt == 0) ? 1 : 0;
      checks++;
      if (doneCnt[d] != expDone) begin
        errors++;
        $display("[TB] FAIL %s doneCount[%0d] got %0d exp %0d", name, d, doneCnt[d], expDone);
      end
      if (abortAt == 0) begin
        checks++;
        if (doneAt[d] != total[d]) begin
          errors++;
          $display("[TB] FAIL %s doneTime[%0d] got %0d exp %0d", name, d, doneAt[d], total[d]);
        end
      end
      checks++;
      if (passV[d] !== expPass) begin
        errors++;
        $display("[TB] FAIL %s pass[%0d] got %b exp %b", name, d, passV[d], expPass);
      end
      checks++;
      if (errV[d] !== 8'(expErrV)) begin
        errors++;
        $display("[TB] FAIL %s errCnt[%0d] got %0d exp %0d", name, d, errV[d], expErrV);
      end
      lastErr[d]  = expErrV;
      lastPass[d] = expPass;
    end
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
    computeExp(0, abortAt, expErrV, firstFail, anyFail);
    checks++;
    if ({failValidA, failVecA} !== {anyFail, 2'(firstFail)}) begin
      errors++;
      $display("[TB] FAIL %s failCapA got %b/%b exp %b/%b", name, failValidA, failVecA,
               anyFail, 2'(firstFail));
    end
`endif
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    applyStimulus(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busyV, validV, doneV, passV} !== 16'h0 || stimAll !== 10'h0) begin
      errors++;
      $display("[TB] FAIL resetFlags got busy=%b valid=%b done=%b pass=%b stim=%h exp all 0",
               busyV, validV, doneV, passV, stimAll);
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (errV[d] !== 8'h00) begin
        errors++;
        $display("[TB] FAIL resetErr[%0d] got %0d exp 0", d, errV[d]);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busyV !== 4'b0) begin
      errors++;
      $display("[TB] FAIL idleAfterReset got busy=%b exp 0000", busyV);
    end
  endtask

  task automatic test_correct;
    applyStimulus(0);
    runSweep("correct", 0, 0);
  endtask

  task automatic test_stuck;
    applyStimulus(1);
    runSweep("stuck1", 0, 0);
    applyStimulus(2);
    runSweep("stuck0", 0, 0);
  endtask

  // start together with abort while idle must be refused and leave the
  // held results of the previous sweep untouched
  task automatic test_abort_start_idle;
    applyStimulus(1);
    runSweep("preHold", 0, 0);
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (busyV !== 4'b0 || doneV !== 4'b0) begin
      errors++;
      $display("[TB] FAIL abortWins got busy=%b done=%b exp 0000 0000", busyV, doneV);
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (errV[d] !== 8'(lastErr[d]) || passV[d] !== lastPass[d]) begin
        errors++;
        $display("[TB] FAIL heldResult[%0d] got err=%0d pass=%b exp err=%0d pass=%b",
                 d, errV[d], passV[d], lastErr[d], lastPass[d]);
      end
    end
  endtask

  task automatic test_abort;
    applyStimulus(0);
    runSweep("abortSettle", 6, 0);
    applyStimulus(1);
    runSweep("abortCheck", 4, 0);
  endtask

  task automatic test_restart;
    applyStimulus(0);
    runSweep("restart", 0, $urandom_range(1, 14));
  endtask

  task automatic test_random;
    int sel;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(3);
      sel = $urandom_range(0, 2);
      if (sel == 0) runSweep("randAbort", $urandom_range(1, 15), 0);
      else if (sel == 1) runSweep("randRestart", 0, $urandom_range(1, 14));
      else runSweep("randPlain", 0, 0);
    end
  endtask

  task automatic test_rst_mid;
    applyStimulus(1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat ($urandom_range(3, 14)) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busyV, validV, doneV, passV} !== 16'h0 || stimAll !== 10'h0) begin
      errors++;
      $display("[TB] FAIL midReset got busy=%b valid=%b done=%b pass=%b stim=%h exp all 0",
               busyV, validV, doneV, passV, stimAll);
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (errV[d] !== 8'h00) begin
        errors++;
        $display("[TB] FAIL midResetErr[%0d] got %0d exp 0", d, errV[d]);
      end
    end
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
    checks++;
    if ({failValidA, failVecA} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL midResetCap got %b/%b exp 0/00", failValidA, failVecA);
    end
`endif
    #1 rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    applyStimulus(1);
    runSweep("b2bFirst", 0, 0);
    applyStimulus(0);
    runSweep("b2bSecond", 0, 0);
  endtask

  // Scenario sequence
  initial begin
    test_reset;
    test_correct;
    test_stuck;
    test_abort_start_idle;
    test_abort;
    test_restart;
    test_random;
    test_rst_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
